// File: rtl/cvfpu_arb_pkg.sv
// Shared types for the multi-port CVFPU arbiter: request record, widths and the channel-id width helper.
package cvfpu_arb_pkg;
  localparam int FPU_WIDTH = 512;
  localparam int STATUS_W  = 5;
  localparam int SIMD_W    = FPU_WIDTH / 64;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0, RM_RTZ = 3'd1, RM_RDN = 3'd2, RM_RUP = 3'd3, RM_RMM = 3'd4, RM_DYN = 3'd7
  } rnd_mode_e;

  typedef struct packed {
    logic [2:0][FPU_WIDTH-1:0] operands;
    rnd_mode_e                 rnd_mode;
    logic [3:0]                op;
    logic                      op_mod;
    logic [2:0]                src_fmt;
    logic [2:0]                dst_fmt;
    logic [1:0]                int_fmt;
    logic [SIMD_W-1:0]         simd_mask;
  } fpu_req_t;

  localparam int REQ_W = $bits(fpu_req_t);

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cvfpu_arb_resp_fifo.sv
// Per-channel response FIFO (result, status, tag); flush empties it in the same cycle.
module cvfpu_arb_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          full;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n) push |-> !full);
endmodule

// File: rtl/cvfpu_port_arbiter.sv
// Round-robin, credit-based sharing of one CVFPU among NUM_CH channels with per-channel response FIFOs.
// Optional CVFPU_ARB_FFLAGS_EN adds per-channel sticky fflags (ch_fflags / ch_fflags_clr).
module cvfpu_port_arbiter
  import cvfpu_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = FPU_WIDTH,
  parameter int TAG_WIDTH = 1,
  parameter int DEPTH     = 4,
  localparam int CH_W     = ch_w(NUM_CH),
  localparam int RTAG_W   = TAG_WIDTH + CH_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic [NUM_CH-1:0]             ch_req_valid,
  output logic [NUM_CH-1:0]             ch_req_ready,
  input  logic [NUM_CH*REQ_W-1:0]       ch_req_bits,
  input  logic [NUM_CH*TAG_WIDTH-1:0]   ch_req_tag,
  output logic                          fpu_req_valid,
  input  logic                          fpu_req_ready,
  output logic [REQ_W-1:0]              fpu_req_bits,
  output logic [RTAG_W-1:0]             fpu_req_tag,
  output logic                          fpu_flush,
  input  logic                          fpu_resp_valid,
  output logic                          fpu_resp_ready,
  input  logic [WIDTH-1:0]              fpu_resp_result,
  input  logic [STATUS_W-1:0]           fpu_resp_status,
  input  logic [RTAG_W-1:0]             fpu_resp_tag,
  output logic [NUM_CH-1:0]             ch_resp_valid,
  input  logic [NUM_CH-1:0]             ch_resp_ready,
  output logic [NUM_CH*WIDTH-1:0]       ch_resp_result,
  output logic [NUM_CH*STATUS_W-1:0]    ch_resp_status,
  output logic [NUM_CH*TAG_WIDTH-1:0]   ch_resp_tag,
`ifdef CVFPU_ARB_FFLAGS_EN
  output logic [NUM_CH*STATUS_W-1:0]    ch_fflags,
  input  logic [NUM_CH-1:0]             ch_fflags_clr,
`endif
  output logic                          busy
);
  localparam int CRED_W = $clog2(DEPTH + 1);
  localparam int FDW    = WIDTH + STATUS_W + TAG_WIDTH;

  logic                 rst_done, lock, gnt_any, fire;
  logic [CH_W-1:0]      rr_ptr, lock_ch, gnt_idx, cand, resp_id;
  logic [CRED_W-1:0]    credit [NUM_CH];
  logic [NUM_CH-1:0]    eligible, push, pop, fifo_empty;
  logic [REQ_W-1:0]     req_bits [NUM_CH];
  logic [TAG_WIDTH-1:0] req_tag [NUM_CH];

  assign fpu_flush      = flush;
  assign fpu_resp_ready = rst_done;
  assign resp_id        = fpu_resp_tag[TAG_WIDTH +: CH_W];

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++) eligible[i] = ch_req_valid[i] && (credit[i] != '0);
  end

  // Scan from the farthest offset down so the channel nearest the pointer wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (lock) begin
      gnt_any = 1'b1;
      gnt_idx = lock_ch;
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        cand = CH_W'((int'(rr_ptr) + k) % NUM_CH);
        if (eligible[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign fpu_req_valid = rst_done && !flush && gnt_any;
  assign fire          = fpu_req_valid && fpu_req_ready;
  assign fpu_req_bits  = req_bits[gnt_idx];
  assign fpu_req_tag   = {gnt_idx, req_tag[gnt_idx]};

  always_comb begin
    ch_req_ready = '0;
    push         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_req_ready[i] = fire && (gnt_idx == CH_W'(i));
      push[i]         = fpu_resp_valid && fpu_resp_ready && !flush && (resp_id == CH_W'(i));
    end
  end

  assign ch_resp_valid = ~fifo_empty;
  assign pop           = ch_resp_valid & ch_resp_ready;

  always_comb begin
    busy = |ch_resp_valid;
    for (int i = 0; i < NUM_CH; i++) if (credit[i] != CRED_W'(DEPTH)) busy = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_done <= 1'b0;
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_ch  <= '0;
      for (int i = 0; i < NUM_CH; i++) credit[i] <= CRED_W'(DEPTH);
    end else begin
      rst_done <= 1'b1;
      if (flush) begin
        lock <= 1'b0;
        for (int i = 0; i < NUM_CH; i++) credit[i] <= CRED_W'(DEPTH);
      end else begin
        lock    <= fpu_req_valid && !fpu_req_ready;
        lock_ch <= gnt_idx;
        if (fire) rr_ptr <= CH_W'((int'(gnt_idx) + 1) % NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_req_ready[i] && !pop[i])      credit[i] <= credit[i] - 1'b1;
          else if (pop[i] && !ch_req_ready[i]) credit[i] <= credit[i] + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [FDW-1:0] fifo_out;

    assign req_bits[i] = ch_req_bits[i*REQ_W +: REQ_W];
    assign req_tag[i]  = ch_req_tag[i*TAG_WIDTH +: TAG_WIDTH];

    cvfpu_arb_resp_fifo #(.DEPTH(DEPTH), .DW(FDW)) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (flush),
      .push      (push[i]),
      .push_data ({fpu_resp_result, fpu_resp_status, fpu_resp_tag[TAG_WIDTH-1:0]}),
      .pop       (pop[i]),
      .pop_data  (fifo_out),
      .empty     (fifo_empty[i])
    );

    assign ch_resp_result[i*WIDTH +: WIDTH]       = fifo_out[FDW-1 -: WIDTH];
    assign ch_resp_status[i*STATUS_W +: STATUS_W] = fifo_out[TAG_WIDTH +: STATUS_W];
    assign ch_resp_tag[i*TAG_WIDTH +: TAG_WIDTH]  = fifo_out[TAG_WIDTH-1:0];

`ifdef CVFPU_ARB_FFLAGS_EN
    logic [STATUS_W-1:0] fflags_q;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)              fflags_q <= '0;
      else if (flush)            fflags_q <= '0;
      else if (ch_fflags_clr[i]) fflags_q <= '0;
      else if (pop[i])           fflags_q <= fflags_q | fifo_out[TAG_WIDTH +: STATUS_W];
    end
    assign ch_fflags[i*STATUS_W +: STATUS_W] = fflags_q;
`endif
  end

  a_resp_id_range: assert property (@(posedge clock) disable iff (!reset_n)
    (fpu_resp_valid && fpu_resp_ready) |-> (int'(resp_id) < NUM_CH));
endmodule
